reg_file_param: RTL and testbench
=================================

# reg_file_param

Parametrised multi-read-port integer register file for the RV32I datapath, replacing the fixed 32x32 two-read-port file in the decode/writeback stage. It is generalised in data width, register count and read-port count, and supports an optional hardwired-zero register. It clears its storage with a sequential post-reset sweep, so storage needs no per-entry reset and can map to distributed RAM. An optional write-to-read bypass removes the writeback-to-decode hazard.

## Interface
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers; power of two, 2..256.
- NRD, 2, number of read ports, 1..4.
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes.
- AW, $clog2(NREGS), derived address width; not for override.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- rf_ready  output  1  high when the sweep is complete and the file accepts writes.
- RegWrite  input  1  write enable.
- Rd  input  AW  write address.
- Write_data  input  XLEN  write data.
- Rs  input  NRD*AW  packed read addresses; port i is Rs[i*AW +: AW].
- read_data  output  NRD*XLEN  packed read data; port i is read_data[i*XLEN +: XLEN].

## Operation
- Two-state FSM: SWEEP and READY.
- SWEEP:
  - Each clock writes 0 to mem[sweep_ptr] and increments sweep_ptr.
  - The clock at which sweep_ptr == NREGS-1 writes the last entry and moves the FSM to READY.
  - sweep_ptr is an AW-bit counter; it is unused after SWEEP and wraps to 0 there.
- READY: terminal state; left only by reset.
- Reset asserted (low), at any time including mid-sweep:
  - Immediately: state = SWEEP, sweep_ptr = 0, rf_ready = 0.
  - Storage contents are not reset directly.
  - The sweep restarts from entry 0 after release.
- Writes:
  - Accepted only in READY with RegWrite = 1.
  - Rd == 0 with ZERO_REG = 1 is dropped.
  - A RegWrite asserted during SWEEP is dropped silently; there is no queueing.
- Reads:
  - Combinational from mem[Rs_i].
  - Forced to 0 while rf_ready = 0.
  - Forced to 0 when Rs_i == 0 and ZERO_REG = 1.
- All NRD ports are independent. Any number of ports may address the same register in the same cycle.

## Timing
- Reset values:
  - rf_ready = 0.
  - read_data = all zeros: reads are masked while rf_ready = 0.
- Sweep latency: rf_ready rises after the NREGS-th rising clk edge following reset deassertion. This is 32 cycles at default.
- Write latency: a write is visible on the read ports after the clk edge that samples it.
- Same-cycle write and read of the same address:
  - Without bypass, the read returns the old value in that cycle.
  - With bypass, see Configuration.
- Reset asserted on the same edge as a write: reset wins, and the write is dropped.
- The first write accepted is on the edge after rf_ready goes high, never on the final sweep edge.

## Configuration
- Macro: RF_WRITE_BYPASS_EN.
- Defined: read_data_i = Write_data combinationally when all of the following hold:
  - rf_ready = 1
  - RegWrite = 1
  - Rd == Rs_i
  - not (ZERO_REG and Rd == 0)
- Defined, effect: the value being written is seen in the same cycle, and the pipeline drops its WB->ID forwarding mux.
- Undefined: no bypass path. Reads always reflect the stored contents as of the last edge.

## Test plan
- Reset low 3 cycles, then high, with NREGS = 32 -> rf_ready = 0 for 32 edges, 1 after the 32nd edge. All read_data = 0 throughout.
- During SWEEP, RegWrite = 1, Rd = 5, Write_data = 0xDEADBEEF -> after READY, Rs0 = 5 reads 0x00000000.
- In READY, write x7 = 0x12345678, then read Rs0 = 7 and Rs1 = 7 on the next cycle -> both ports return 0x12345678. Write Rd = 0 with 0xFFFFFFFF -> Rs0 = 0 reads 0.
- Same cycle: write x3 = 0xA5A5A5A5 and read Rs0 = 3, old value 0x11111111 -> 0xA5A5A5A5 with RF_WRITE_BYPASS_EN, 0x11111111 without; 0xA5A5A5A5 on the next cycle in both builds.
- Reset asserted at sweep entry 10, released 2 cycles later, with x20 written to 0x55 before the first reset -> rf_ready returns exactly 32 edges after the second release, and x20 reads 0.
- Parameter build XLEN = 64, NREGS = 16, NRD = 4, ZERO_REG = 0 -> rf_ready after 16 edges. Write x0 = 0x0123456789ABCDEF -> all four ports with Rs = 0 return that value.

Source files
------------

// File: rtl/reg_file_param.sv
// ============================================================================
//  reg_file_param
//  Parametrised multi-read-port register file cleared by a post-reset sweep.
//  Optional feature macro: RF_WRITE_BYPASS_EN (same-cycle write-to-read bypass).
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_param #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                rf_ready,
  input  logic                RegWrite,
  input  logic [AW-1:0]       Rd,
  input  logic [XLEN-1:0]     Write_data,
  input  logic [NRD*AW-1:0]   Rs,
  output logic [NRD*XLEN-1:0] read_data
);

  typedef enum logic [0:0] {
    SWEEP = 1'b0,
    READY = 1'b1
  } state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   sweep_ptr_q, sweep_ptr_d;
  logic            rf_ready_q, rf_ready_d;

  logic [XLEN-1:0] mem [NREGS];

  logic            zero_wr;
  logic            user_we;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_wdata;

  always_comb begin
    state_d     = state_q;
    sweep_ptr_d = sweep_ptr_q;
    rf_ready_d  = rf_ready_q;
    if (state_q == SWEEP) begin
      sweep_ptr_d = sweep_ptr_q + AW'(1);
      if (sweep_ptr_q == LAST_IDX) begin
        state_d    = READY;
        rf_ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SWEEP;
      sweep_ptr_q <= '0;
      rf_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_ptr_q <= sweep_ptr_d;
      rf_ready_q  <= rf_ready_d;
    end
  end

  // Reset forces SWEEP asynchronously, so a write coinciding with reset is
  // dropped without gating storage by reset; sweep writes during reset only
  // rewrite entry 0 with zero.
  always_comb begin
    zero_wr   = (ZERO_REG != 0) && (Rd == '0);
    user_we   = (state_q == READY) && RegWrite && !zero_wr;
    mem_we    = (state_q == SWEEP) || user_we;
    mem_addr  = (state_q == SWEEP) ? sweep_ptr_q : Rd;
    mem_wdata = (state_q == SWEEP) ? '0 : Write_data;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  generate
    for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   rs;
      logic [XLEN-1:0] rdata;

      assign rs = Rs[i*AW +: AW];

      always_comb begin
        rdata = '0;
        if (rf_ready_q && !((ZERO_REG != 0) && (rs == '0))) begin
          rdata = mem[rs];
`ifdef RF_WRITE_BYPASS_EN
          if (user_we && (Rd == rs)) begin
            rdata = Write_data;
          end
`endif
        end
      end

      assign read_data[i*XLEN +: XLEN] = rdata;
    end
  endgenerate

  assign rf_ready = rf_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_param.sv
// ============================================================================
//  tb_reg_file_param
//  Directed self-checking bench: default build plus a 64-bit/16-entry/4-port
//  build without a zero register.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default build: XLEN 32, NREGS 32, NRD 2, ZERO_REG 1
  logic         rst_a;
  logic         rdy_a;
  logic         we_a;
  logic [4:0]   rd_a;
  logic [31:0]  wd_a;
  logic [9:0]   rs_a;
  logic [63:0]  rdata_a;

  // wide build: XLEN 64, NREGS 16, NRD 4, ZERO_REG 0
  logic         rst_b;
  logic         rdy_b;
  logic         we_b;
  logic [3:0]   rd_b;
  logic [63:0]  wd_b;
  logic [15:0]  rs_b;
  logic [255:0] rdata_b;

  int n_vec = 0;
  int n_err = 0;

  reg_file_param u_dut_a (
    .clk        (clk),
    .reset      (rst_a),
    .rf_ready   (rdy_a),
    .RegWrite   (we_a),
    .Rd         (rd_a),
    .Write_data (wd_a),
    .Rs         (rs_a),
    .read_data  (rdata_a)
  );

  reg_file_param #(
    .XLEN     (64),
    .NREGS    (16),
    .NRD      (4),
    .ZERO_REG (0)
  ) u_dut_b (
    .clk        (clk),
    .reset      (rst_b),
    .rf_ready   (rdy_b),
    .RegWrite   (we_b),
    .Rd         (rd_b),
    .Write_data (wd_b),
    .Rs         (rs_b),
    .read_data  (rdata_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [4:0] addr, input logic [31:0] data);
    we_a = 1'b1;
    rd_a = addr;
    wd_a = data;
    step();
    we_a = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_same;

    rst_a = 1'b0; we_a = 1'b1; rd_a = 5'd5; wd_a = 32'hDEADBEEF; rs_a = {5'd5, 5'd5};
    rst_b = 1'b0; we_b = 1'b0; rd_b = '0;   wd_b = '0;           rs_b = '0;

    // reset held low 3 cycles, with a write pending the whole time
    repeat (3) step();
    check("rst_ready", {63'd0, rdy_a}, 64'd0);
    check("rst_rdata", rdata_a, 64'd0);
    rst_a = 1'b1;

    // sweep: ready only after the 32nd edge, reads masked, write to x5 ignored
    for (int i = 1; i <= 32; i++) begin
      step();
      check($sformatf("sweep_rdy_%0d", i), {63'd0, rdy_a}, (i == 32) ? 64'd1 : 64'd0);
      if (i < 32) check($sformatf("sweep_rd_%0d", i), rdata_a, 64'd0);
    end
    we_a = 1'b0;
    #1;
    check("sweep_wr_dropped", {32'd0, rdata_a[31:0]}, 64'd0);

    // write x7, read on both ports
    wr_a(5'd7, 32'h12345678);
    rs_a = {5'd7, 5'd7};
    #1;
    check("x7_p0", {32'd0, rdata_a[31:0]},  64'h12345678);
    check("x7_p1", {32'd0, rdata_a[63:32]}, 64'h12345678);

    // x0 hardwired to zero
    wr_a(5'd0, 32'hFFFFFFFF);
    rs_a = {5'd7, 5'd0};
    #1;
    check("x0_zero", {32'd0, rdata_a[31:0]}, 64'd0);

    // same-cycle write and read of x3
    wr_a(5'd3, 32'h11111111);
    we_a = 1'b1; rd_a = 5'd3; wd_a = 32'hA5A5A5A5; rs_a = {5'd7, 5'd3};
    #1;
`ifdef RF_WRITE_BYPASS_EN
    exp_same = 32'hA5A5A5A5;
`else
    exp_same = 32'h11111111;
`endif
    check("same_cyc_p0", {32'd0, rdata_a[31:0]},  {32'd0, exp_same});
    check("same_cyc_p1", {32'd0, rdata_a[63:32]}, 64'h12345678);
    step();
    we_a = 1'b0;
    #1;
    check("next_cyc_x3", {32'd0, rdata_a[31:0]}, 64'hA5A5A5A5);

    // bypass never applies to a dropped x0 write
    we_a = 1'b1; rd_a = 5'd0; wd_a = 32'hCAFEF00D; rs_a = {5'd0, 5'd0};
    #1;
    check("x0_no_bypass", rdata_a, 64'd0);
    we_a = 1'b0;

    // x20 = 0x55, then reset, re-reset at sweep entry 10
    wr_a(5'd20, 32'h00000055);
    rs_a = {5'd7, 5'd20};
    #1;
    check("x20_set", {32'd0, rdata_a[31:0]}, 64'h55);
    rst_a = 1'b0;
    #1;
    check("async_rst_rdy", {63'd0, rdy_a}, 64'd0);
    check("async_rst_rd", rdata_a, 64'd0);
    step();
    rst_a = 1'b1;
    repeat (10) step();
    rst_a = 1'b0;
    step();
    step();
    rst_a = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      check($sformatf("resweep_rdy_%0d", i), {63'd0, rdy_a}, (i == 32) ? 64'd1 : 64'd0);
    end
    check("x20_cleared", {32'd0, rdata_a[31:0]},  64'd0);
    check("x7_cleared",  {32'd0, rdata_a[63:32]}, 64'd0);

    // wide build
    rst_b = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("b_sweep_rdy_%0d", i), {63'd0, rdy_b}, (i == 16) ? 64'd1 : 64'd0);
    end
    we_b = 1'b1; rd_b = 4'd0; wd_b = 64'h0123456789ABCDEF;
    step();
    we_b = 1'b1; rd_b = 4'd15; wd_b = 64'hFEDCBA9876543210;
    step();
    we_b = 1'b0;
    rs_b = {4'd0, 4'd0, 4'd0, 4'd0};
    #1;
    for (int p = 0; p < 4; p++) begin
      check($sformatf("b_x0_p%0d", p), rdata_b[p*64 +: 64], 64'h0123456789ABCDEF);
    end
    rs_b = {4'd15, 4'd0, 4'd15, 4'd1};
    #1;
    check("b_mix_p0", rdata_b[63:0],    64'd0);
    check("b_mix_p1", rdata_b[127:64],  64'hFEDCBA9876543210);
    check("b_mix_p2", rdata_b[191:128], 64'h0123456789ABCDEF);
    check("b_mix_p3", rdata_b[255:192], 64'hFEDCBA9876543210);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
